// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake plus operand and result buses
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder with start/busy/done handshake
module serial_adder #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res, sum_q;
    logic [WIDTH:0] res_sh;
    logic [CW-1:0] cnt;
    logic c, s, c_nx, cout_q, last;
    assign s = a_sh[0] ^ b_sh[0] ^ c;
    assign c_nx = (a_sh[0] & b_sh[0]) | (c & (a_sh[0] ^ b_sh[0]));
    assign res_sh = {s, res} >> 1;
    assign last = cnt == CW'(WIDTH - 1);
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // next state: DONE always falls back to IDLE so start is never queued
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (bus.start ? ADD : IDLE) :
                   (state == ADD)  ? (last ? DONE : ADD) : IDLE;
    end
    // operand capture, one full-adder step per ADD cycle, result publish on the last bit
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            res <= '0;
            c <= 1'b0;
            cnt <= '0;
            sum_q <= '0;
            cout_q <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            c <= bus.cin;
            cnt <= '0;
        end else if (state == ADD) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res <= res_sh[WIDTH-1:0];
            c <= c_nx;
            cnt <= cnt + 1'b1;
            if (last) begin
                sum_q <= res_sh[WIDTH-1:0];
                cout_q <= c_nx;
            end
        end
    end
    assign bus.busy = state == ADD;
    assign bus.done = state == DONE;
    assign bus.sum = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed table plus corner sequences and random regression at WIDTH 1, 8 and 13
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic cin = 1'b0;
    int sel = 8;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(1))  if1 ();
    serial_adder_if #(.WIDTH(8))  if8 ();
    serial_adder_if #(.WIDTH(13)) if13 ();

    assign if1.start = start && sel == 1;
    assign if8.start = start && sel == 8;
    assign if13.start = start && sel == 13;
    assign if1.a = a[0:0];
    assign if1.b = b[0:0];
    assign if8.a = a[7:0];
    assign if8.b = b[7:0];
    assign if13.a = a[12:0];
    assign if13.b = b[12:0];
    assign if1.cin = cin;
    assign if8.cin = cin;
    assign if13.cin = cin;

    serial_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(if1));
    serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    serial_adder #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst), .bus(if13));

    logic busy_m, done_m, cout_m;
    logic [31:0] sum_m;
    assign busy_m = sel == 1 ? if1.busy : sel == 13 ? if13.busy : if8.busy;
    assign done_m = sel == 1 ? if1.done : sel == 13 ? if13.done : if8.done;
    assign cout_m = sel == 1 ? if1.cout : sel == 13 ? if13.cout : if8.cout;
    assign sum_m = sel == 1 ? 32'(if1.sum) : sel == 13 ? 32'(if13.sum) : 32'(if8.sum);

    typedef struct {
        int w;
        logic [31:0] a;
        logic [31:0] b;
        logic ci;
        logic [31:0] s;
        logic co;
        bit noise;
        bit hold;
        logic [31:0] hv;
    } vec_t;
    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // one full handshake; cycle k is the k-th cycle after the start edge
    task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic cv,
                          input bit noise, input bit hold, input logic [31:0] hv,
                          output logic [31:0] s, output logic co,
                          output int lat, output int nbusy, output int ndone);
        sel = w;
        s = '0;
        co = 1'b0;
        lat = -1;
        nbusy = 0;
        ndone = 0;
        @(negedge clk);
        start = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        cin = 1'b1;
        for (int k = 1; k <= w + 2; k++) begin
            if (k > 1) @(negedge clk);
            if (busy_m) nbusy++;
            if (done_m) begin
                ndone++;
                if (lat < 0) begin
                    lat = k;
                    s = sum_m;
                    co = cout_m;
                end
            end
            if (hold && k <= w) check("hold_sum", 64'(sum_m), 64'(hv));
            if (noise && (k == 2 || k == w + 1)) begin
                start = 1'b1;
                a = 32'h0F;
                b = 32'hF0;
                cin = 1'b0;
            end else start = 1'b0;
        end
        start = 1'b0;
    endtask

    logic [31:0] rs;
    logic rco;
    int lat, nbusy, ndone, nd;
    logic [32:0] t;
    logic [32:0] mask;
    logic [31:0] ra, rb;
    logic rc;

    initial begin
        vecs[0]  = '{1, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1, 32'd0, 32'd0, 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[2]  = '{1, 32'd0, 32'd1, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[3]  = '{1, 32'd0, 32'd1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[4]  = '{1, 32'd1, 32'd0, 1'b0, 32'd1, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[5]  = '{1, 32'd1, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[6]  = '{1, 32'd1, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[7]  = '{1, 32'd1, 32'd1, 1'b1, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[8]  = '{8, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[9]  = '{8, 32'hFF, 32'hFF, 1'b1, 32'hFF, 1'b1, 1'b0, 1'b0, 32'd0};
        vecs[10] = '{8, 32'h5A, 32'h25, 1'b0, 32'h7F, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[11] = '{8, 32'h12, 32'h34, 1'b0, 32'h46, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[12] = '{8, 32'h01, 32'h01, 1'b0, 32'h02, 1'b0, 1'b0, 1'b1, 32'h46};
        vecs[13] = '{8, 32'h3C, 32'h42, 1'b1, 32'h7F, 1'b0, 1'b1, 1'b0, 32'd0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            sel = vecs[i].w;
            if (i == 0 || i == 8) begin
                #1;
                check("reset_busy", 64'(busy_m), 64'd0);
                check("reset_done", 64'(done_m), 64'd0);
                check("reset_sum", 64'(sum_m), 64'd0);
                check("reset_cout", 64'(cout_m), 64'd0);
            end
        end
        sel = 13;
        #1;
        check("reset_sum_w13", 64'(sum_m), 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].noise, vecs[i].hold, vecs[i].hv,
                   rs, rco, lat, nbusy, ndone);
            check($sformatf("vec%0d_sum", i), 64'(rs), 64'(vecs[i].s));
            check($sformatf("vec%0d_cout", i), 64'(rco), 64'(vecs[i].co));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].w + 1));
            check($sformatf("vec%0d_busy_cycles", i), 64'(nbusy), 64'(vecs[i].w));
            check($sformatf("vec%0d_done_pulses", i), 64'(ndone), 64'd1);
        end

        sel = 8;
        @(negedge clk);
        start = 1'b1;
        a = 32'hFF;
        b = 32'h01;
        cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 64'(busy_m), 64'd0);
        check("midrst_done", 64'(done_m), 64'd0);
        check("midrst_sum", 64'(sum_m), 64'd0);
        check("midrst_cout", 64'(cout_m), 64'd0);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_m || busy_m) nd++;
        end
        check("midrst_no_done", 64'(nd), 64'd0);
        run_op(8, 32'h80, 32'h80, 1'b0, 1'b0, 1'b0, 32'd0, rs, rco, lat, nbusy, ndone);
        check("post_rst_sum", 64'(rs), 64'h00);
        check("post_rst_cout", 64'(rco), 64'd1);
        check("post_rst_latency", 64'(lat), 64'd9);

        for (int p = 0; p < 2; p++) begin
            automatic int w = p == 0 ? 8 : 13;
            mask = (33'd1 << w) - 33'd1;
            for (int n = 0; n < 1000; n++) begin
                ra = $urandom & mask[31:0];
                rb = $urandom & mask[31:0];
                rc = 1'($urandom);
                t = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
                run_op(w, ra, rb, rc, 1'b0, 1'b0, 32'd0, rs, rco, lat, nbusy, ndone);
                check($sformatf("rand_w%0d_sum a=%0h b=%0h c=%0d", w, ra, rb, rc), 64'(rs), 64'(t & mask));
                check($sformatf("rand_w%0d_cout a=%0h b=%0h c=%0d", w, ra, rb, rc), 64'(rco), 64'(t[w]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
